// File: rtl/carry_select_sub_pkg.sv
// rtl/carry_select_sub_pkg.sv - shared sizes and stage payload types for the borrow-select subtractor
// Optional feature macro: SUB_SIGNED_OVF_EN (adds signed-overflow fields to the stage payloads).
package carry_select_sub_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int BLOCK_DEF = 4;
  localparam int NBLK      = WIDTH_DEF / BLOCK_DEF;
  localparam int HALF_DEF  = WIDTH_DEF / 2;

  // Stage 1 payload: low half resolved, high half kept as two candidates.
  typedef struct packed {
    logic [HALF_DEF-1:0] lo_diff;
    logic                mid_borrow;
    logic [HALF_DEF-1:0] hi_diff0;
    logic [HALF_DEF-1:0] hi_diff1;
    logic                hi_bout0;
    logic                hi_bout1;
`ifdef SUB_SIGNED_OVF_EN
    logic                a_msb;
    logic                b_msb;
`endif
  } s1_t;

  // Stage 2 payload: the delivered result.
  typedef struct packed {
    logic [WIDTH_DEF-1:0] diff;
    logic                 bout;
`ifdef SUB_SIGNED_OVF_EN
    logic                 ovf;
`endif
  } s2_t;

endpackage

// File: rtl/carry_select_subtractor16_pipe_block.sv
// rtl/carry_select_subtractor16_pipe_block.sv - one BLOCK-bit slice producing both borrow candidates
// Ports:
//   a, b          : BLOCK-bit operand slices
//   diff0, bout0  : slice result assuming block borrow-in = 0
//   diff1, bout1  : slice result assuming block borrow-in = 1
module csel_sub_block
  import carry_select_sub_pkg::*;
#(
  parameter int BLOCK = BLOCK_DEF
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  output logic [BLOCK-1:0] diff0,
  output logic             bout0,
  output logic [BLOCK-1:0] diff1,
  output logic             bout1
);

  logic [BLOCK:0] sum0;
  logic [BLOCK:0] sum1;

  // a - b - borrow == a + ~b + (1 - borrow); borrow-out is the inverted carry.
  assign sum0 = {1'b0, a} + {1'b0, ~b} + {{BLOCK{1'b0}}, 1'b1};
  assign sum1 = {1'b0, a} + {1'b0, ~b};

  assign diff0 = sum0[BLOCK-1:0];
  assign bout0 = ~sum0[BLOCK];
  assign diff1 = sum1[BLOCK-1:0];
  assign bout1 = ~sum1[BLOCK];

endmodule

// File: rtl/carry_select_subtractor16_pipe.sv
// rtl/carry_select_subtractor16_pipe.sv - two-stage pipelined borrow-select subtractor with valid/ready
// Optional feature macro: SUB_SIGNED_OVF_EN (adds registered signed-overflow output ovf).
// Ports:
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid, in_ready   : operand handshake (a, b, bin)
//   out_valid, out_ready : result handshake (diff, bout[, ovf])
//   diff = (a - b - bin) mod 2^WIDTH, bout = 1 when a < b + bin (unsigned)
module carry_select_subtractor16_pipe
  import carry_select_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int BLOCK = BLOCK_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NB = WIDTH / BLOCK;
  localparam int HB = NB / 2;

  logic [BLOCK-1:0] blk_d0 [NB];
  logic [BLOCK-1:0] blk_d1 [NB];
  logic             blk_b0 [NB];
  logic             blk_b1 [NB];

  for (genvar i = 0; i < NB; i++) begin : g_blk
    csel_sub_block #(.BLOCK(BLOCK)) u_blk (
      .a     (a[i*BLOCK +: BLOCK]),
      .b     (b[i*BLOCK +: BLOCK]),
      .diff0 (blk_d0[i]),
      .bout0 (blk_b0[i]),
      .diff1 (blk_d1[i]),
      .bout1 (blk_b1[i])
    );
  end

  s1_t  s1_q, s1_next;
  s2_t  s2_q, s2_next;
  logic s1_valid;
  logic s2_load;
  logic in_fire;
  logic lo_brw, hi_brw0, hi_brw1;

  // Low half: select chain driven by bin. High half: two chains, one per
  // possible mid_borrow value, so stage 2 only needs a final mux.
  always_comb begin
    s1_next = '0;
    lo_brw  = bin;
    hi_brw0 = 1'b0;
    hi_brw1 = 1'b1;
    for (int i = 0; i < HB; i++) begin
      s1_next.lo_diff[i*BLOCK +: BLOCK]  = lo_brw ? blk_d1[i] : blk_d0[i];
      lo_brw                             = lo_brw ? blk_b1[i] : blk_b0[i];
      s1_next.hi_diff0[i*BLOCK +: BLOCK] = hi_brw0 ? blk_d1[HB+i] : blk_d0[HB+i];
      hi_brw0                            = hi_brw0 ? blk_b1[HB+i] : blk_b0[HB+i];
      s1_next.hi_diff1[i*BLOCK +: BLOCK] = hi_brw1 ? blk_d1[HB+i] : blk_d0[HB+i];
      hi_brw1                            = hi_brw1 ? blk_b1[HB+i] : blk_b0[HB+i];
    end
    s1_next.mid_borrow = lo_brw;
    s1_next.hi_bout0   = hi_brw0;
    s1_next.hi_bout1   = hi_brw1;
`ifdef SUB_SIGNED_OVF_EN
    s1_next.a_msb      = a[WIDTH-1];
    s1_next.b_msb      = b[WIDTH-1];
`endif
  end

  always_comb begin
    s2_next      = '0;
    s2_next.diff = {s1_q.mid_borrow ? s1_q.hi_diff1 : s1_q.hi_diff0, s1_q.lo_diff};
    s2_next.bout = s1_q.mid_borrow ? s1_q.hi_bout1 : s1_q.hi_bout0;
`ifdef SUB_SIGNED_OVF_EN
    s2_next.ovf  = (s1_q.a_msb != s1_q.b_msb) && (s2_next.diff[WIDTH-1] != s1_q.a_msb);
`endif
  end

  // Output register loads whenever it is empty or being drained; stage 1
  // moves along with it, so a full pipe still accepts while draining.
  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_q      <= '0;
      s2_q      <= '0;
      out_valid <= 1'b0;
    end else begin
      if (in_fire) begin
        s1_q     <= s1_next;
        s1_valid <= 1'b1;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          s2_q <= s2_next;
        end
      end
    end
  end

  assign diff = s2_q.diff;
  assign bout = s2_q.bout;
`ifdef SUB_SIGNED_OVF_EN
  assign ovf  = s2_q.ovf;
`endif

endmodule
